// File: rtl/pulse_stretcher_if.sv
// Event-in / level-out signal bundle for pulse_stretcher.
// The master drives strobes and the overflow clear. The slave returns the stretched level and the queue status.
interface pulse_stretcher_if #(
   parameter int PEND_W = 2
);
   logic              Pi;
   logic              ClrOvf;
   logic              Lo;
   logic              Busy;
   logic [PEND_W-1:0] Pending;
   logic              Overflow;

   modport master (
      output Pi, ClrOvf,
      input  Lo, Busy, Pending, Overflow
   );

   modport slave (
      input  Pi, ClrOvf,
      output Lo, Busy, Pending, Overflow
   );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches each one-clock event strobe into a HOLD_CYCLES-long high level on Lo.
// Each high phase is followed by a GAP_CYCLES forced-low gap. Events that arrive early wait in a saturating counter.
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 2
) (
   input  logic              Clk,
   input  logic              ResetN,
   pulse_stretcher_if.slave  bus
);
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [PEND_W-1:0] pend, pend_n;
   logic              ovf, ovf_n;
   logic              from_q, start, launch, ovf_set;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state <= S_IDLE;
         cnt   <= '0;
         pend  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pend  <= pend_n;
         ovf   <= ovf_n;
      end
   end

   always_comb begin
      from_q  = (pend != '0);
      start   = bus.Pi | from_q;
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      launch  = 1'b0;
      ovf_set = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) launch = 1'b1;
         end
         S_HOLD: begin
            if (cnt == '0) begin
               state_n = S_GAP;
               cnt_n   = GAP_LD;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               if (start) launch  = 1'b1;
               else       state_n = S_IDLE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase

      // A queued start pops one entry; a coincident Pi refills it, so the count is unchanged.
      if (launch) begin
         state_n = S_HOLD;
         cnt_n   = HOLD_LD;
         if (from_q && !bus.Pi) pend_n = pend - 1'b1;
      end else if (bus.Pi && (state == S_HOLD || state == S_GAP)) begin
         if (pend == PEND_MAX) ovf_set = 1'b1;
         else                  pend_n  = pend + 1'b1;
      end

      if (ovf_set)         ovf_n = 1'b1;
      else if (bus.ClrOvf) ovf_n = 1'b0;
      else                 ovf_n = ovf;
   end

   assign bus.Lo       = (state == S_HOLD);
   assign bus.Busy     = (state != S_IDLE);
   assign bus.Pending  = pend;
   assign bus.Overflow = ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed checks of pulse_stretcher at HOLD=4, GAP=2, PEND_W=2.
module tb_pulse_stretcher;
   logic Clk = 1'b0;
   logic ResetN = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pulse_stretcher_if #(.PEND_W(2)) bus ();

   pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) dut (
      .Clk    (Clk),
      .ResetN (ResetN),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic pi, input logic clr);
      bus.Pi     = pi;
      bus.ClrOvf = clr;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      logic [31:0] lov, bsv;
      int rises, lo_prev, lo_seen;

      bus.Pi     = 1'b0;
      bus.ClrOvf = 1'b0;

      // reset state
      #2 ResetN = 1'b0;
      #1;
      chk("rst_lo", bus.Lo, 0);
      chk("rst_busy", bus.Busy, 0);
      chk("rst_pend", bus.Pending, 0);
      chk("rst_ovf", bus.Overflow, 0);
      repeat (2) @(posedge Clk);
      @(negedge Clk) ResetN = 1'b1;

      // 1: single event
      lov = 0; bsv = 0;
      step(1, 0);
      lov = {lov[30:0], bus.Lo}; bsv = {bsv[30:0], bus.Busy};
      for (int i = 0; i < 6; i++) begin
         step(0, 0);
         lov = {lov[30:0], bus.Lo}; bsv = {bsv[30:0], bus.Busy};
      end
      chk("t1_lo_pattern", lov, 32'b1111000);
      chk("t1_busy_pattern", bsv, 32'b1111110);
      chk("t1_pend", bus.Pending, 0);

      // 2: three back-to-back events
      lov = 0;
      for (int i = 0; i < 18; i++) begin
         step(i < 3, 0);
         lov = {lov[30:0], bus.Lo};
         if (i == 2)  chk("t2_pend_after3", bus.Pending, 2);
         if (i == 6)  chk("t2_pend_2nd_start", bus.Pending, 1);
         if (i == 12) chk("t2_pend_3rd_start", bus.Pending, 0);
      end
      chk("t2_lo_pattern", lov, 32'b111100111100111100);
      chk("t2_ovf", bus.Overflow, 0);
      step(0, 0);
      chk("t2_idle", bus.Busy, 0);

      // 3: five events saturate the queue
      rises = 0; lo_prev = 0;
      for (int i = 0; i < 27; i++) begin
         step(i < 5, 0);
         if (bus.Lo && !lo_prev) rises++;
         lo_prev = bus.Lo;
         if (i == 3) begin
            chk("t3_pend_sat", bus.Pending, 3);
            chk("t3_ovf_pre", bus.Overflow, 0);
         end
         if (i == 4) chk("t3_ovf_set", bus.Overflow, 1);
      end
      chk("t3_pulses", rises, 4);
      chk("t3_ovf_sticky", bus.Overflow, 1);
      step(0, 1);
      chk("t3_ovf_clr", bus.Overflow, 0);
      step(0, 0);

      // 4: new event in the last gap cycle restarts with no idle cycle
      lov = 0; bsv = 0;
      for (int i = 0; i < 13; i++) begin
         step(i == 0 || i == 6, 0);
         lov = {lov[30:0], bus.Lo}; bsv = {bsv[30:0], bus.Busy};
      end
      chk("t4_lo_pattern", lov, 32'b1111001111000);
      chk("t4_busy_pattern", bsv, 32'b1111111111110);

      // 5: async reset mid-hold with two queued events
      step(1, 0); step(1, 0); step(1, 0); step(0, 0);
      chk("t5_pend_pre", bus.Pending, 2);
      chk("t5_lo_pre", bus.Lo, 1);
      #2 ResetN = 1'b0;
      #1;
      chk("t5_lo_rst", bus.Lo, 0);
      chk("t5_busy_rst", bus.Busy, 0);
      chk("t5_pend_rst", bus.Pending, 0);
      @(negedge Clk) ResetN = 1'b1;
      lo_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, 0);
         lo_seen |= bus.Lo;
      end
      chk("t5_no_pulse", lo_seen, 0);

      // 6: set beats clear in the same cycle
      for (int i = 0; i < 4; i++) step(1, 0);
      chk("t6_pend", bus.Pending, 3);
      step(1, 1);
      chk("t6_set_wins", bus.Overflow, 1);
      step(0, 1);
      chk("t6_clr", bus.Overflow, 0);
      for (int i = 0; i < 25; i++) step(0, 0);
      chk("t6_drain_busy", bus.Busy, 0);
      chk("t6_drain_pend", bus.Pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
